// File: rtl/life_grid_reader_if.sv
// rtl/life_grid_reader_if.sv - row stream bus between the grid reader and its sink
interface life_grid_reader_if #(
    parameter int N = 8
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  row_data;
    logic [IW-1:0] row_idx;
    logic          row_valid;
    logic          row_ready;

    modport master (
        output row_data,
        output row_idx,
        output row_valid,
        input  row_ready
    );

    modport slave (
        input  row_data,
        input  row_idx,
        input  row_valid,
        output row_ready
    );
endinterface

// File: rtl/life_grid_reader.sv
// rtl/life_grid_reader.sv - streams a captured N*N life board out one row per handshake (optional LIFE_POPCOUNT_EN)
module life_grid_reader #(
    parameter int N   = 8,
    parameter int GCW = 16,
    localparam int IW  = (N > 1) ? $clog2(N) : 1,
    localparam int PCW = $clog2(N * N + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [N*N-1:0]          grid_i,
    input  logic                    gen_strobe_i,
    life_grid_reader_if.master      row_if,
    output logic                    frame_done_o,
    output logic                    busy_o,
    output logic [GCW-1:0]          gen_count_o,
    output logic [7:0]              drop_cnt_o,
    output logic [PCW-1:0]          pop_count_o
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N*N-1:0]   shadow_q, shadow_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [GCW-1:0]   gen_q, gen_d;
    logic [7:0]       drop_q, drop_d;
    logic [N-1:0]     row_sel;

    // State and frame registers; reset abandons any frame in flight
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            idx_q    <= '0;
            gen_q    <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            gen_q    <= gen_d;
            drop_q   <= drop_d;
        end
    end

    // Next-state logic: capture on strobe in IDLE, walk rows in SEND, count in DONE
    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        idx_d        = idx_q;
        gen_d        = gen_q;
        drop_d       = drop_q;
        frame_done_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (gen_strobe_i) begin
                    shadow_d = grid_i;
                    idx_d    = '0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (gen_strobe_i && drop_q != 8'hFF) begin
                    drop_d = drop_q + 8'd1;
                end
                if (row_if.row_ready) begin
                    if (idx_q == IW'(N - 1)) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            DONE: begin
                frame_done_o = 1'b1;
                gen_d        = gen_q + GCW'(1);
                if (gen_strobe_i && drop_q != 8'hFF) begin
                    drop_d = drop_q + 8'd1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Row mux: select the shadow slice addressed by the current row index
    always_comb begin
        row_sel = '0;
        for (int r = 0; r < N; r++) begin
            if (idx_q == IW'(r)) begin
                row_sel = shadow_q[r*N +: N];
            end
        end
    end

    assign row_if.row_data  = row_sel;
    assign row_if.row_idx   = idx_q;
    assign row_if.row_valid = (state_q == SEND);
    assign busy_o           = (state_q == SEND) || (state_q == DONE);
    assign gen_count_o      = gen_q;
    assign drop_cnt_o       = drop_q;

`ifdef LIFE_POPCOUNT_EN
    logic [PCW-1:0] pop_q, pop_sum;

    // Live-cell count of the shadow board, combinational adder chain
    always_comb begin
        pop_sum = '0;
        for (int k = 0; k < N * N; k++) begin
            pop_sum = pop_sum + PCW'(shadow_q[k]);
        end
    end

    // Latch the count when the frame completes; hold until the next frame
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pop_q <= '0;
        end else if (state_q == DONE) begin
            pop_q <= pop_sum;
        end
    end

    assign pop_count_o = pop_q;
`else
    assign pop_count_o = '0;
`endif
endmodule

// File: tb/tb_life_grid_reader.sv
// tb/tb_life_grid_reader.sv - randomized self-checking bench for life_grid_reader
module tb_life_grid_reader;
    localparam int N   = 8;
    localparam int GCW = 16;
    localparam int PCW = $clog2(N * N + 1);

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*N-1:0]  grid;
    logic            strobe;
    logic            frame_done;
    logic            busy;
    logic [GCW-1:0]  gen_count;
    logic [7:0]      drop_cnt;
    logic [PCW-1:0]  pop_count;

    life_grid_reader_if #(.N(N)) rif ();

    life_grid_reader #(.N(N), .GCW(GCW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .grid_i       (grid),
        .gen_strobe_i (strobe),
        .row_if       (rif.master),
        .frame_done_o (frame_done),
        .busy_o       (busy),
        .gen_count_o  (gen_count),
        .drop_cnt_o   (drop_cnt),
        .pop_count_o  (pop_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [GCW-1:0] exp_gen;
    int             exp_drop;
    int             exp_pop;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pop_model(input logic [N*N-1:0] g);
`ifdef LIFE_POPCOUNT_EN
        return $countones(g);
`else
        return 0;
`endif
    endfunction

    function automatic logic [N*N-1:0] rand_grid();
        return {$urandom, $urandom};
    endfunction

    task automatic note_drop();
        if (exp_drop < 255) exp_drop++;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, rif.row_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_fdone"}, frame_done, 0);
        check({tag, "_gen"}, gen_count, exp_gen);
        check({tag, "_drop"}, drop_cnt, exp_drop);
        check({tag, "_pop"}, pop_count, exp_pop);
    endtask

    // One frame: strobe g, then consume rows, checking each against the stored grid
    task automatic run_frame(input logic [N*N-1:0] g, input int stall_row, input int stall_len,
                             input bit rnd_ready, input int over_start, input int n_over,
                             input bit done_strobe, output int cyc);
        int c;
        int exp_row;
        int stall_left;
        int exp_len;
        bit done;
        @(negedge clk);
        grid = g;
        strobe = 1'b1;
        rif.row_ready = 1'($urandom_range(0, 1));
        c = 0;
        exp_row = 0;
        stall_left = stall_len;
        exp_len = N + 1;
        done = 0;
        while (!done && c < 2000) begin
            @(negedge clk);
            c++;
            strobe = 1'b0;
            grid = rand_grid();
            if (n_over > 0 && c >= over_start && c < over_start + n_over) begin
                strobe = 1'b1;
                grid = ~g;
                note_drop();
            end
            if (frame_done) begin
                check("done_row", exp_row, N);
                check("done_len", c, exp_len);
                check("done_busy", busy, 1);
                check("done_valid", rif.row_valid, 0);
                exp_gen = exp_gen + 1'b1;
                exp_pop = pop_model(g);
                if (done_strobe) begin
                    strobe = 1'b1;
                    note_drop();
                end
                done = 1;
            end else if (exp_row >= N) begin
                check("frame_done", frame_done, 1);
                done = 1;
            end else begin
                check("valid", rif.row_valid, 1);
                check("busy", busy, 1);
                check("row_idx", rif.row_idx, exp_row);
                check("row_data", rif.row_data, g[exp_row*N +: N]);
                if (exp_row == stall_row && stall_left > 0) begin
                    rif.row_ready = 1'b0;
                    stall_left--;
                end else if (rnd_ready) begin
                    rif.row_ready = 1'($urandom_range(0, 1));
                end else begin
                    rif.row_ready = 1'b1;
                end
                if (rif.row_ready) exp_row++;
                else exp_len++;
            end
        end
        if (!done) check("timeout", 0, 1);
        cyc = c;
        @(negedge clk);
        strobe = 1'b0;
        rif.row_ready = 1'($urandom_range(0, 1));
        check_idle("post");
    endtask

    initial begin
        int cyc;
        logic [N*N-1:0] g;
        exp_gen = '0;
        exp_drop = 0;
        exp_pop = 0;
        rst_n = 1'b0;
        strobe = 1'b0;
        grid = '0;
        rif.row_ready = 1'b0;

        // T1: reset held with random inputs
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            grid = rand_grid();
            strobe = 1'($urandom_range(0, 1));
            rif.row_ready = 1'($urandom_range(0, 1));
            #1;
            check("rst_data", rif.row_data, 0);
            check("rst_idx", rif.row_idx, 0);
            check_idle("rst");
        end
        @(negedge clk);
        strobe = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("idle0");

        // T2: single lit cell, back-to-back rows
        run_frame(64'h1, -1, 0, 0, 0, 0, 0, cyc);
        check("t2_len", cyc, 9);
        check("t2_gen", gen_count, 1);

        // T3: backpressure on row 3
        run_frame(rand_grid(), 3, 5, 0, 0, 0, 0, cyc);
        check("t3_len", cyc, 14);

        // T4: one overrun mid-frame, then a saturating burst
        run_frame(rand_grid(), -1, 0, 0, 3, 1, 0, cyc);
        check("t4_drop1", drop_cnt, 1);
        run_frame(rand_grid(), 0, 300, 0, 2, 300, 0, cyc);
        check("t4_drop_sat", drop_cnt, 255);

        // Strobe coinciding with DONE must not start a frame
        run_frame(rand_grid(), -1, 0, 0, 0, 0, 1, cyc);
        check("done_strobe_idle", rif.row_valid, 0);

        // Randomized grids with random backpressure
        for (int i = 0; i < 8; i++) begin
            run_frame(rand_grid(), -1, 0, 1, 0, 0, 0, cyc);
        end

        // T6: population count
        run_frame(64'hFF00_0000_0000_00F0, -1, 0, 0, 0, 0, 0, cyc);
`ifdef LIFE_POPCOUNT_EN
        check("t6_pop", pop_count, 12);
`else
        check("t6_pop", pop_count, 0);
`endif

        // T5: reset during row 4
        g = rand_grid();
        @(negedge clk);
        grid = g;
        strobe = 1'b1;
        rif.row_ready = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        check("t5_idx4", rif.row_idx, 4);
        check("t5_data4", rif.row_data, g[4*N +: N]);
        rst_n = 1'b0;
        #1;
        exp_gen = '0;
        exp_drop = 0;
        exp_pop = 0;
        check("t5_rst_idx", rif.row_idx, 0);
        check_idle("t5_rst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_no_done", frame_done, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("t5_rel");
        run_frame(rand_grid(), -1, 0, 0, 0, 0, 0, cyc);
        check("t5_len", cyc, 9);
        check("t5_gen", gen_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
